cordic_vectoring: RTL and testbench

//  Iterative CORDIC in vectoring mode. It is the inverse direction of the pipelined rotation-mode cosine

---
 rtl/cordic_vectoring.sv | 171 +++++++++++++++++
 tb/tb_cordic_vectoring.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: one micro-rotation per enabled clock, returning
// atan2(y,x) and the gain-scaled magnitude K*sqrt(x^2+y^2) of a fixed-point vector.
module cordic_vectoring #(
    parameter int WIDTH = 24,
    parameter int ITERS = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   x_in,
    input  logic [WIDTH:0]   y_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH+2:0] theta,
    output logic [WIDTH+2:0] mag,
    output logic [1:0]       dbg_state
);
    // Handshake: a transfer happens on a rising edge where valid and ready are both 1
    // and clk_en=1; out_valid stays high with stable data until out_ready takes it.

    localparam int IW = WIDTH + 4;
    localparam int CW = $clog2(ITERS + 1);
    localparam int SH = 24 - WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    // Q3.24 reference constants rescaled to WIDTH fractional bits, round-half-up.
    function automatic logic [31:0] q324_scale(input logic [31:0] v);
        if (SH == 0) begin
            return v;
        end
        return (v + ((32'd1 << SH) >> 1)) >> SH;
    endfunction

    function automatic logic [31:0] atan_base(input int k);
        case (k)
            0:       return 32'hC90FDB;
            1:       return 32'h76B19C;
            2:       return 32'h3EB6EC;
            3:       return 32'h1FD5BA;
            4:       return 32'h0FFAAD;
            5:       return 32'h07FF55;
            6:       return 32'h03FFEA;
            7:       return 32'h01FFFD;
            8:       return 32'h00FFFF;
            9:       return 32'h007FFF;
            default: begin
                if (k >= 10 && k <= 23) begin
                    return (32'd1 << (24 - k)) - 32'd1;
                end
                return 32'd0;
            end
        endcase
    endfunction

    localparam logic signed [IW-1:0] PI_Z = IW'(q324_scale(32'h3243F6B));

    state_t               state_q, state_nxt;
    logic [CW-1:0]        iter_q;
    logic                 zero_q;
    logic signed [IW-1:0] x_q, y_q, z_q;
    logic [WIDTH+2:0]     theta_q, mag_q;
    logic                 out_valid_q;

    logic signed [IW-1:0] x_ext, y_ext;
    logic signed [IW-1:0] x_pre, y_pre, z_pre;
    logic signed [IW-1:0] x_sh, y_sh, atan_i;
    logic signed [IW-1:0] x_rot, y_rot, z_rot;
    logic                 last_iter;
    logic                 in_zero;

    assign in_ready  = (state_q == IDLE) && clk_en;
    assign out_valid = out_valid_q;
    assign theta     = theta_q;
    assign mag       = mag_q;
    assign dbg_state = state_q;

    assign last_iter = (iter_q == CW'(ITERS - 1));
    assign in_zero   = (x_in == '0) && (y_in == '0);

    // Next-state logic.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: if (in_valid)  state_nxt = ITER;
            ITER: if (last_iter) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    // Quadrant prescale folds the left half-plane onto the right, preloading z with +-PI.
    always_comb begin
        x_ext = {{(IW - WIDTH - 1){x_in[WIDTH]}}, x_in};
        y_ext = {{(IW - WIDTH - 1){y_in[WIDTH]}}, y_in};
        x_pre = x_ext;
        y_pre = y_ext;
        z_pre = '0;
        if (x_in[WIDTH]) begin
            x_pre = -x_ext;
            y_pre = -y_ext;
            z_pre = y_in[WIDTH] ? -PI_Z : PI_Z;
        end
    end

    // One micro-rotation driving y toward zero; shifts use the pre-edge x and y.
    always_comb begin
        x_sh   = x_q >>> iter_q;
        y_sh   = y_q >>> iter_q;
        atan_i = IW'(q324_scale(atan_base(int'(iter_q))));
        x_rot  = x_q + y_sh;
        y_rot  = y_q - x_sh;
        z_rot  = z_q + atan_i;
        if (y_q[IW-1]) begin
            x_rot = x_q - y_sh;
            y_rot = y_q + x_sh;
            z_rot = z_q - atan_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            iter_q      <= '0;
            zero_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            theta_q     <= '0;
            mag_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (clk_en) begin
            state_q <= state_nxt;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        x_q    <= x_pre;
                        y_q    <= y_pre;
                        z_q    <= z_pre;
                        zero_q <= in_zero;
                        iter_q <= '0;
                    end
                end
                ITER: begin
                    x_q    <= x_rot;
                    y_q    <= y_rot;
                    z_q    <= z_rot;
                    iter_q <= iter_q + CW'(1);
                    if (last_iter) begin
                        out_valid_q <= 1'b1;
                        theta_q     <= zero_q ? '0 : z_rot[WIDTH+2:0];
                        mag_q       <= zero_q ? '0 : x_rot[WIDTH+2:0];
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_vectoring.sv
// Directed bench for cordic_vectoring: a driver issues operands and queues expected
// results; a monitor pops and compares each time out_valid rises.
module tb_cordic_vectoring;
    localparam int WIDTH = 24;
    localparam int ITERS = 24;
    localparam int LAT   = ITERS;

    logic             clk = 1'b0;
    logic             reset;
    logic             clk_en;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:0]   x_in;
    logic [WIDTH:0]   y_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH+2:0] theta;
    logic [WIDTH+2:0] mag;
    logic [1:0]       dbg_state;

    cordic_vectoring #(.WIDTH(WIDTH), .ITERS(ITERS)) dut (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (clk_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .theta     (theta),
        .mag       (mag),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    typedef struct {
        int th;
        int mg;
        int tol_t;
        int tol_m;
        int lat;
        int acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Hand-computed angles (Q3.24); magnitudes come from the real-valued gain model.
    localparam int NV = 8;
    logic [WIDTH:0] vx  [NV] = '{25'h0800000, 25'h1800000, 25'h1800000, 25'h0000000,
                                 25'h1000000, 25'h1000000, 25'h0800000, 25'h0000000};
    logic [WIDTH:0] vy  [NV] = '{25'h0800000, 25'h0000000, 25'h1FFFFFF, 25'h0000000,
                                 25'h0000000, 25'h1000000, 25'h1800000, 25'h1800000};
    int             vth [NV] = '{32'h0C90FDB, 32'h3243F6B, -32'h3243F6B, 0,
                                 32'h3243F6B, -32'h25B2F90, -32'h0C90FDB, -32'h1921FB6};

    task automatic check(input string name, input int act, input int exp, input int tol);
        int d;
        n_vec++;
        d = act - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) tol %0d",
                     name, act, act, exp, exp, tol);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    function automatic real to_real(input logic [WIDTH:0] v);
        return $itor($signed(v)) / 16777216.0;
    endfunction

    function automatic int rnd(input real r);
        if (r >= 0.0) return $rtoi(r + 0.5);
        return -$rtoi(-r + 0.5);
    endfunction

    // Expected magnitude K*sqrt(x^2+y^2) with K taken over ITERS micro-rotations.
    function automatic int model_mag(input logic [WIDTH:0] x, input logic [WIDTH:0] y);
        real k = 1.0;
        real p = 1.0;
        real xr, yr;
        for (int i = 0; i < ITERS; i++) begin
            k = k * $sqrt(1.0 + p);
            p = p / 4.0;
        end
        xr = to_real(x);
        yr = to_real(y);
        return rnd(k * $sqrt(xr * xr + yr * yr) * 16777216.0);
    endfunction

    // ---------------- driver ----------------
    task automatic send(input logic [WIDTH:0] x, input logic [WIDTH:0] y, input int th,
                        input bit push, input int lat);
        exp_t e;
        int   waited = 0;
        bit   zero;
        @(negedge clk);
        x_in     = x;
        y_in     = y;
        in_valid = 1'b1;
        while (!in_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            timeout_fail("accept");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        zero    = (x == '0) && (y == '0);
        e.th    = th;
        e.mg    = zero ? 0 : model_mag(x, y);
        e.tol_t = zero ? 0 : 8;
        e.tol_m = zero ? 0 : 16;
        e.lat   = lat;
        e.acc   = cyc;
        if (push) exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || out_valid) timeout_fail("drain");
    endtask

    // ---------------- monitor ----------------
    logic ov_prev = 1'b0;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (out_valid && !ov_prev) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_output: theta=0x%0h mag=0x%0h at cycle %0d",
                         theta, mag, cyc);
            end else begin
                e = exp_q.pop_front();
                check("latency", cyc - e.acc, e.lat, 0);
                check("theta", int'($signed(theta)), e.th, e.tol_t);
                check("mag", int'(mag), e.mg, e.tol_m);
            end
        end
        ov_prev = out_valid;
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        reset     = 1'b1;
        clk_en    = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x_in      = '0;
        y_in      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", int'(out_valid), 0, 0);
        check("reset_theta", int'(theta), 0, 0);
        check("reset_mag", int'(mag), 0, 0);
        check("reset_in_ready", int'(in_ready), 1, 0);
        check("reset_state", int'(dbg_state), 0, 0);
        reset = 1'b0;

        // Directed table, out_ready held high.
        for (int i = 0; i < NV; i++) begin
            send(vx[i], vy[i], vth[i], 1'b1, LAT);
        end
        wait_drain();

        // Consumer back-pressure: result must hold for 10 cycles.
        @(negedge clk);
        out_ready = 1'b0;
        send(25'h0800000, 25'h0800000, 32'h0C90FDB, 1'b1, LAT);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) timeout_fail("hold_wait");
        for (int k = 0; k < 10; k++) begin
            check("hold_out_valid", int'(out_valid), 1, 0);
            check("hold_in_ready", int'(in_ready), 0, 0);
            check("hold_theta", int'($signed(theta)), 32'h0C90FDB, 8);
            check("hold_mag", int'(mag), model_mag(25'h0800000, 25'h0800000), 16);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_out_valid", int'(out_valid), 0, 0);
        check("release_in_ready", int'(in_ready), 1, 0);
        check("release_state", int'(dbg_state), 0, 0);
        send(25'h0000000, 25'h0800000, 32'h1921FB6, 1'b1, LAT);
        wait_drain();

        // Clock-enable stall of 5 cycles starting at i=10.
        send(25'h0800000, 25'h0800000, 32'h0C90FDB, 1'b1, LAT + 5);
        repeat (10) @(negedge clk);
        clk_en = 1'b0;
        repeat (5) begin
            check("stall_in_ready", int'(in_ready), 0, 0);
            @(negedge clk);
        end
        clk_en = 1'b1;
        wait_drain();

        // Reset mid-operation at i=12 drops the operation.
        send(25'h0800000, 25'h0800000, 32'h0C90FDB, 1'b0, LAT);
        repeat (12) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_in_ready", int'(in_ready), 1, 0);
        check("abort_out_valid", int'(out_valid), 0, 0);
        check("abort_theta", int'(theta), 0, 0);
        check("abort_mag", int'(mag), 0, 0);
        send(25'h0000000, 25'h0800000, 32'h1921FB6, 1'b1, LAT);
        wait_drain();
        repeat (40) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
